// File: rtl/mac_pkg.sv
// Shared definitions for the mac_v1 operand/result path.
//   DW, RW    : default operand and MAC result widths
//   state_e   : dot-product sequencing states of the driver
//   shadow_w  : width of the exact (non-wrapping) shadow sum
package mac_pkg;

  localparam int DW = 8;
  localparam int RW = 22;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    HOLD
  } state_e;

  // One spare bit above the worst-case growth keeps the overflow test exact.
  function automatic int shadow_w(input int rw, input int vec_len);
    return rw + $clog2(vec_len) + 1;
  endfunction

endpackage

// File: rtl/mac_vec_driver_if.sv
// Operand/result bus between mac_vec_driver and its environment.
//   in_valid/in_ready/in_a/in_b             : operand pair stream into the driver
//   mac_a/mac_b/mac_clr/mac_result          : operand feed to and accumulator from the MAC
//   out_valid/out_ready/out_result/out_overflow : dot-product result stream
// master : the driver side; slave : operand source, MAC and result consumer.
interface mac_vec_driver_if #(
  parameter int DW = 8,
  parameter int RW = 22
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;

  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic          mac_clr;
  logic [RW-1:0] mac_result;

  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;
  logic          out_overflow;

  modport master (
    input  in_valid, in_a, in_b, mac_result, out_ready,
    output in_ready, mac_a, mac_b, mac_clr, out_valid, out_result, out_overflow
  );

  modport slave (
    output in_valid, in_a, in_b, mac_result, out_ready,
    input  in_ready, mac_a, mac_b, mac_clr, out_valid, out_result, out_overflow
  );

endinterface

// File: rtl/mac_op_fifo.sv
// Synchronous FIFO for MAC operand words, first-word-fall-through read port.
//   clk_i, rst_ni : clock, asynchronous active-low reset (empties the FIFO)
//   push_i        : write wdata_i (ignored while full)
//   pop_i         : drop head entry (ignored while empty)
//   wdata_i       : word to store
//   rdata_o       : current head entry
//   full_o/empty_o: occupancy flags
module mac_op_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [CNTW-1:0] cnt_q;
  logic            push_ok;
  logic            pop_ok;

  assign full_o  = (cnt_q == CNTW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNTW'(1);
        2'b01:   cnt_q <= cnt_q - CNTW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mac_vec_driver.sv
// Driver end of the mac_v1 interface: buffers operand pairs, feeds VEC_LEN
// pairs per dot product into an external MAC (clearing it first), and returns
// the accumulated result with an overflow flag.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : operand stream in, MAC feed/result, result stream out (master side)
//   busy : sequencer not idle
module mac_vec_driver #(
  parameter int DW         = mac_pkg::DW,
  parameter int RW         = mac_pkg::RW,
  parameter int VEC_LEN    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAC_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  mac_vec_driver_if.master bus,
  output logic             busy
);

  import mac_pkg::*;

  localparam int SW = shadow_w(RW, VEC_LEN);
  localparam int CW = $clog2(VEC_LEN + 1);
  localparam int LW = $clog2(MAC_LAT + 1);
  localparam int PW = 2 * DW;

  localparam logic [CW-1:0] CNT_LAST = CW'(VEC_LEN - 1);
  localparam logic [LW-1:0] LAT_END  = LW'(MAC_LAT);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [LW-1:0] lat_q;
  logic [SW-1:0] sum_q;
  logic [DW-1:0] mac_a_q;
  logic [DW-1:0] mac_b_q;
  logic          mac_clr_q;
  logic          out_valid_q;
  logic [RW-1:0] out_result_q;
  logic          out_ovf_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [PW-1:0] fifo_rdata;
  logic [DW-1:0] head_a;
  logic [DW-1:0] head_b;
  logic [PW-1:0] prod;

  mac_op_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (bus.in_valid),
    .pop_i   (fifo_pop),
    .wdata_i ({bus.in_a, bus.in_b}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_a = fifo_rdata[PW-1:DW];
  assign head_b = fifo_rdata[DW-1:0];
  assign prod   = PW'(head_a) * PW'(head_b);

  // FEED always leaves on the VEC_LEN-th pop, so no count guard is needed here.
  assign fifo_pop = (state_q == FEED) && !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lat_q        <= '0;
      sum_q        <= '0;
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      mac_clr_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      // Zero operands unless popping, so idle cycles leave the MAC unchanged.
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= CLEAR;
          end
        end
        CLEAR: begin
          mac_clr_q <= 1'b1;
          cnt_q     <= '0;
          sum_q     <= '0;
          state_q   <= FEED;
        end
        FEED: begin
          if (fifo_pop) begin
            mac_a_q <= head_a;
            mac_b_q <= head_b;
            sum_q   <= sum_q + SW'(prod);
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              lat_q   <= '0;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Entered on the last operand edge; the MAC output settles MAC_LAT
          // edges later and is sampled on the edge after that.
          if (lat_q == LAT_END) begin
            out_result_q <= bus.mac_result;
            out_ovf_q    <= |sum_q[SW-1:RW];
            out_valid_q  <= 1'b1;
            state_q      <= HOLD;
          end else begin
            lat_q <= lat_q + LW'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= fifo_empty ? IDLE : CLEAR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = !fifo_full;
  assign bus.mac_a        = mac_a_q;
  assign bus.mac_b        = mac_b_q;
  assign bus.mac_clr      = mac_clr_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_overflow = out_ovf_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mac_vec_driver.sv
module tb_mac_vec_driver;

  localparam int DW = 8;
  localparam int RW = 22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  mac_vec_driver_if #(.DW(DW), .RW(RW)) if1 ();
  mac_vec_driver_if #(.DW(DW), .RW(RW)) if2 ();
  logic busy1;
  logic busy2;

  mac_vec_driver #(
    .DW(DW), .RW(RW), .VEC_LEN(4), .FIFO_DEPTH(4), .MAC_LAT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(if1.master), .busy(busy1)
  );

  mac_vec_driver #(
    .DW(DW), .RW(RW), .VEC_LEN(70), .FIFO_DEPTH(4), .MAC_LAT(1)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(if2.master), .busy(busy2)
  );

  // MAC models: result <= clr ? 0 : result + a*b, wrapping at RW bits.
  logic [RW-1:0] mac1_q = '0;
  logic [RW-1:0] mac2_q = '0;
  always @(posedge clk) mac1_q <= if1.mac_clr ? '0 : mac1_q + RW'(if1.mac_a) * RW'(if1.mac_b);
  always @(posedge clk) mac2_q <= if2.mac_clr ? '0 : mac2_q + RW'(if2.mac_a) * RW'(if2.mac_b);
  assign if1.mac_result = mac1_q;
  assign if2.mac_result = mac2_q;

  // Observer of dut1, sampling 2 time units after the falling edge.
  int cyc = 0;
  int clr_cnt = 0;
  int last_clr_cyc = -1;
  int valid_cycles = 0;
  int busy_rise_cyc = -1;
  int ov_rise_cyc = -1;
  logic prev_busy = 1'b0;
  logic prev_ov = 1'b0;
  logic [RW-1:0] res_q [$];
  logic          ovf_q [$];
  logic [DW-1:0] opa_q [$];
  logic [DW-1:0] opb_q [$];
  int            opc_q [$];

  always begin
    @(negedge clk);
    #2;
    cyc++;
    if (if1.mac_clr) begin
      clr_cnt++;
      last_clr_cyc = cyc;
    end
    if (if1.mac_a != 0 || if1.mac_b != 0) begin
      opa_q.push_back(if1.mac_a);
      opb_q.push_back(if1.mac_b);
      opc_q.push_back(cyc);
    end
    if (if1.out_valid) valid_cycles++;
    if (if1.out_valid && !prev_ov) ov_rise_cyc = cyc;
    if (busy1 && !prev_busy) busy_rise_cyc = cyc;
    if (if1.out_valid && if1.out_ready) begin
      res_q.push_back(if1.out_result);
      ovf_q.push_back(if1.out_overflow);
    end
    prev_ov   = if1.out_valid;
    prev_busy = busy1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic push(input bit sel, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n = 0;
    if (!sel) begin
      if1.in_valid = 1'b1; if1.in_a = a; if1.in_b = b;
    end else begin
      if2.in_valid = 1'b1; if2.in_a = a; if2.in_b = b;
    end
    while (((sel ? if2.in_ready : if1.in_ready) == 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL push_accept got in_ready=0 expected=1");
    end
    @(negedge clk);
    if (!sel) if1.in_valid = 1'b0;
    else      if2.in_valid = 1'b0;
  endtask

  task automatic wait_res(input int target);
    int n = 0;
    while (res_q.size() < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL result_wait got=%0d results expected=%0d", res_q.size(), target);
    end
  endtask

  task automatic wait_valid1();
    int n = 0;
    while (!if1.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL valid_wait got out_valid=0 expected=1");
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (if1.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b expected=1", if1.in_ready); end
    checks++; if (if1.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b expected=0", if1.out_valid); end
    checks++; if (if1.mac_clr !== 1'b0) begin failures++; $display("FAIL rst_mac_clr got=%b expected=0", if1.mac_clr); end
    checks++; if ({if1.mac_a, if1.mac_b} !== 16'h0) begin failures++; $display("FAIL rst_mac_ab got=%h expected=0", {if1.mac_a, if1.mac_b}); end
    checks++; if (if1.out_result !== 22'd0) begin failures++; $display("FAIL rst_out_result got=%0d expected=0", if1.out_result); end
    checks++; if (if1.out_overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b expected=0", if1.out_overflow); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b expected=0", busy1); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int base = res_q.size();
    int op0  = opa_q.size();
    int clr0 = clr_cnt;
    int vc0  = valid_cycles;
    if1.out_ready = 1'b1;
    push(0, 8'd134, 8'd120);
    push(0, 8'd10,  8'd10);
    push(0, 8'd101, 8'd21);
    push(0, 8'd20,  8'd20);
    wait_res(base + 1);
    repeat (3) @(negedge clk);
    checks++; if (res_q[base] !== 22'd18701) begin failures++; $display("FAIL b2b_result got=%0d expected=18701", res_q[base]); end
    checks++; if (ovf_q[base] !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b expected=0", ovf_q[base]); end
    checks++; if (clr_cnt - clr0 != 1) begin failures++; $display("FAIL b2b_clr_pulses got=%0d expected=1", clr_cnt - clr0); end
    checks++; if (opa_q.size() - op0 != 4) begin failures++; $display("FAIL b2b_op_count got=%0d expected=4", opa_q.size() - op0); end
    checks++; if (opa_q[op0] !== 8'd134 || opb_q[op0] !== 8'd120) begin failures++; $display("FAIL b2b_first_op got=%0d,%0d expected=134,120", opa_q[op0], opb_q[op0]); end
    checks++; if (last_clr_cyc != opc_q[op0] - 1) begin failures++; $display("FAIL b2b_clr_before_op got=%0d expected=%0d", last_clr_cyc, opc_q[op0] - 1); end
    checks++; if (valid_cycles - vc0 != 1) begin failures++; $display("FAIL b2b_valid_cycles got=%0d expected=1", valid_cycles - vc0); end
    checks++; if (ov_rise_cyc - busy_rise_cyc != 7) begin failures++; $display("FAIL b2b_latency got=%0d expected=7", ov_rise_cyc - busy_rise_cyc); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL b2b_idle_after got=%b expected=0", busy1); end
  endtask

  task automatic test_gaps();
    int base = res_q.size();
    int op0  = opa_q.size();
    logic [DW-1:0] va [4] = '{8'd134, 8'd10, 8'd101, 8'd20};
    logic [DW-1:0] vb [4] = '{8'd120, 8'd10, 8'd21, 8'd20};
    if1.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(0, va[i], vb[i]);
      if (i < 3) repeat (2) @(negedge clk);
    end
    wait_res(base + 1);
    repeat (3) @(negedge clk);
    checks++; if (res_q[base] !== 22'd18701) begin failures++; $display("FAIL gap_result got=%0d expected=18701", res_q[base]); end
    checks++; if (opa_q.size() - op0 != 4) begin failures++; $display("FAIL gap_op_count got=%0d expected=4", opa_q.size() - op0); end
    if (opa_q.size() - op0 >= 4) begin
      checks++; if (opc_q[op0 + 3] - opc_q[op0] != 7) begin failures++; $display("FAIL gap_feed_span got=%0d expected=7", opc_q[op0 + 3] - opc_q[op0]); end
      checks++; if (opa_q[op0 + 2] !== 8'd101 || opb_q[op0 + 2] !== 8'd21) begin failures++; $display("FAIL gap_third_op got=%0d,%0d expected=101,21", opa_q[op0 + 2], opb_q[op0 + 2]); end
    end
  endtask

  task automatic test_hold_stable();
    int base = res_q.size();
    int clr0;
    int op0;
    if1.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 8'd20, 8'd20);
    for (int i = 0; i < 4; i++) push(0, 8'd1, 8'd1);
    wait_valid1();
    clr0 = clr_cnt;
    op0  = opa_q.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (if1.out_valid !== 1'b1 || if1.out_result !== 22'd1600) begin failures++; $display("FAIL hold_stable cyc=%0d got=%b/%0d expected=1/1600", i, if1.out_valid, if1.out_result); end
    end
    checks++; if (clr_cnt != clr0 || opa_q.size() != op0) begin failures++; $display("FAIL hold_no_start got clr=%0d ops=%0d expected=0/0", clr_cnt - clr0, opa_q.size() - op0); end
    checks++; if (if1.in_ready !== 1'b0) begin failures++; $display("FAIL hold_fifo_full got=%b expected=0", if1.in_ready); end
    if1.out_ready = 1'b1;
    wait_res(base + 2);
    checks++; if (res_q[base] !== 22'd1600) begin failures++; $display("FAIL hold_first got=%0d expected=1600", res_q[base]); end
    checks++; if (res_q[base + 1] !== 22'd4) begin failures++; $display("FAIL hold_second got=%0d expected=4", res_q[base + 1]); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fifo_full();
    int base = res_q.size();
    int op0  = opa_q.size();
    int n    = 0;
    logic [DW-1:0] exp_a [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
    logic [DW-1:0] exp_b [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,  8'd1,  8'd1};
    if1.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(0, exp_a[i], exp_b[i]);
    wait_valid1();
    for (int i = 4; i < 8; i++) push(0, exp_a[i], exp_b[i]);
    checks++; if (if1.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b expected=0", if1.in_ready); end
    if1.in_valid = 1'b1; if1.in_a = exp_a[8]; if1.in_b = exp_b[8];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (if1.in_ready !== 1'b0) begin failures++; $display("FAIL full_stall cyc=%0d got=%b expected=0", i, if1.in_ready); end
    end
    if1.out_ready = 1'b1;
    while (!if1.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 50) begin failures++; $display("FAIL full_release got in_ready=0 expected=1"); end
    @(negedge clk);
    if1.in_valid = 1'b0;
    for (int i = 9; i < 12; i++) push(0, exp_a[i], exp_b[i]);
    wait_res(base + 3);
    repeat (3) @(negedge clk);
    checks++; if (res_q[base] !== 22'd30) begin failures++; $display("FAIL full_res0 got=%0d expected=30", res_q[base]); end
    checks++; if (res_q[base + 1] !== 22'd26) begin failures++; $display("FAIL full_res1 got=%0d expected=26", res_q[base + 1]); end
    checks++; if (res_q[base + 2] !== 22'd42) begin failures++; $display("FAIL full_res2 got=%0d expected=42", res_q[base + 2]); end
    checks++; if (opa_q.size() - op0 != 12) begin failures++; $display("FAIL full_op_count got=%0d expected=12", opa_q.size() - op0); end
    for (int i = 0; i < 12 && op0 + i < opa_q.size(); i++) begin
      checks++; if (opa_q[op0 + i] !== exp_a[i] || opb_q[op0 + i] !== exp_b[i]) begin failures++; $display("FAIL full_op_order idx=%0d got=%0d,%0d expected=%0d,%0d", i, opa_q[op0 + i], opb_q[op0 + i], exp_a[i], exp_b[i]); end
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    if2.out_ready = 1'b1;
    for (int i = 0; i < 70; i++) push(1, 8'd255, 8'd255);
    while (!if2.out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 300) begin failures++; $display("FAIL ovf_wait got out_valid=0 expected=1"); end
    checks++; if (if2.out_result !== 22'd357446) begin failures++; $display("FAIL ovf_result got=%0d expected=357446", if2.out_result); end
    checks++; if (if2.out_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b expected=1", if2.out_overflow); end
    repeat (3) @(negedge clk);
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL ovf_idle_after got=%b expected=0", busy2); end
  endtask

  task automatic test_reset_mid();
    int base;
    int op0;
    int seen = 0;
    int n    = 0;
    if1.out_ready = 1'b1;
    push(0, 8'd9, 8'd9);
    push(0, 8'd8, 8'd8);
    push(0, 8'd7, 8'd7);
    push(0, 8'd6, 8'd6);
    while (n < 20) begin
      if (if1.mac_a != 0) seen++;
      if (seen == 2) break;
      @(negedge clk);
      n++;
    end
    checks++; if (seen != 2) begin failures++; $display("FAIL mid_two_pops got=%0d expected=2", seen); end
    #1 rst = 1'b0;
    #1;
    checks++; if ({if1.mac_a, if1.mac_b} !== 16'h0) begin failures++; $display("FAIL mid_mac_ab got=%h expected=0", {if1.mac_a, if1.mac_b}); end
    checks++; if (if1.out_valid !== 1'b0 || if1.mac_clr !== 1'b0) begin failures++; $display("FAIL mid_valid_clr got=%b%b expected=00", if1.out_valid, if1.mac_clr); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b expected=0", busy1); end
    checks++; if (if1.in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b expected=1", if1.in_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = res_q.size();
    op0  = opa_q.size();
    push(0, 8'd1, 8'd2);
    push(0, 8'd3, 8'd4);
    push(0, 8'd5, 8'd6);
    push(0, 8'd7, 8'd8);
    wait_res(base + 1);
    repeat (10) @(negedge clk);
    checks++; if (res_q[base] !== 22'd100) begin failures++; $display("FAIL mid_fresh_result got=%0d expected=100", res_q[base]); end
    checks++; if (opa_q.size() - op0 != 4) begin failures++; $display("FAIL mid_op_count got=%0d expected=4", opa_q.size() - op0); end
    checks++; if (busy1 !== 1'b0 || res_q.size() != base + 1) begin failures++; $display("FAIL mid_no_leftover got busy=%b results=%0d expected=0/1", busy1, res_q.size() - base); end
  endtask

  initial begin
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.out_ready = 1'b0;
    if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0; if2.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_hold_stable();
    test_fifo_full();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
